// File: rtl/dsp48e2_alu_pkg.sv
// Shared constants for the DSP48E2-style ALU slice.
// Holds the operand widths, the X/Y/Z/W multiplexer select encodings and the
// ALUMODE operation encodings used by dsp48e2_alu.
package dsp48e2_alu_pkg;

  localparam int unsigned AWidth = 30;
  localparam int unsigned BWidth = 18;
  localparam int unsigned PWidth = 48;

  // X = opmode[1:0]
  typedef enum logic [1:0] {
    XZero = 2'b00,
    XM    = 2'b01,
    XP    = 2'b10,
    XAb   = 2'b11
  } x_sel_e;

  // Y = opmode[3:2]; 01 would be the second partial product, folded into X here.
  typedef enum logic [1:0] {
    YZero = 2'b00,
    YPp   = 2'b01,
    YOnes = 2'b10,
    YC    = 2'b11
  } y_sel_e;

  // Z = opmode[6:4]; PCIN and the shifted selections are not provided.
  typedef enum logic [2:0] {
    ZZero  = 3'b000,
    ZPcin  = 3'b001,
    ZP     = 3'b010,
    ZC     = 3'b011,
    ZPMacc = 3'b100
  } z_sel_e;

  // W = opmode[8:7]; RND is fixed at 0.
  typedef enum logic [1:0] {
    WZero = 2'b00,
    WP    = 2'b01,
    WRnd  = 2'b10,
    WC    = 2'b11
  } w_sel_e;

  typedef enum logic [3:0] {
    AluAdd      = 4'b0000,
    AluNegZAdd  = 4'b0001,
    AluNotSum   = 4'b0010,
    AluZSub     = 4'b0011
  } alu_op_e;

endpackage

// File: rtl/dsp48e2_pipe_reg.sv
// Optional pipeline register with clock enable and asynchronous active-low reset.
// Depth 0 is a straight wire; Depth 1 is a single enabled register.
// Ports: clk_i clock, rst_ni async reset, en_i clock enable, d_i data in, q_o data out.
module dsp48e2_pipe_reg #(
  parameter int unsigned Width = 48,
  parameter int unsigned Depth = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = clk_i ^ rst_ni ^ en_i;
    assign q_o = d_i;
  end else begin : g_reg
    logic [Width-1:0] q_d, q_q;

    always_comb begin
      q_d = en_i ? d_i : q_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q_q <= '0;
      end else begin
        q_q <= q_d;
      end
    end

    assign q_o = q_q;
  end

endmodule

// File: rtl/dsp48e2_alu.sv
// DSP48E2-style 48-bit ALU slice with optional A/B/C input and P output registers.
// Ports: clock, reset (async active-low), a/b/c operands, carryin/carryinsel,
//        opmode (W/Z/Y/X selects), alumode, cea/ceb/cec/cep enables,
//        p result, pcout cascade copy of p, carryout carry out of bit 47.
// Build option: define DSP48E2_ALU_MULT_EN to enable the 27x18 signed multiplier
// feeding M; otherwise M is tied to 0.
module dsp48e2_alu
  import dsp48e2_alu_pkg::*;
#(
  parameter int unsigned AREG = 0,
  parameter int unsigned BREG = 0,
  parameter int unsigned CREG = 0,
  parameter int unsigned PREG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AWidth-1:0] a,
  input  logic [BWidth-1:0] b,
  input  logic [PWidth-1:0] c,
  input  logic              carryin,
  input  logic [2:0]        carryinsel,
  input  logic [8:0]        opmode,
  input  logic [3:0]        alumode,
  input  logic              cea,
  input  logic              ceb,
  input  logic              cec,
  input  logic              cep,
  output logic [PWidth-1:0] p,
  output logic [PWidth-1:0] pcout,
  output logic              carryout
);

  logic [AWidth-1:0] a_r;
  logic [BWidth-1:0] b_r;
  logic [PWidth-1:0] c_r;
  logic [PWidth-1:0] m, pfb;
  logic [PWidth-1:0] x_mux, y_mux, z_mux, w_mux;
  logic [PWidth+1:0] addend, sum;
  logic [PWidth-1:0] alu_res;
  logic              alu_co, cin;
  logic [PWidth:0]   p_out;

  dsp48e2_pipe_reg #(.Width(AWidth), .Depth(AREG)) u_areg (
    .clk_i(clock), .rst_ni(reset), .en_i(cea), .d_i(a), .q_o(a_r)
  );
  dsp48e2_pipe_reg #(.Width(BWidth), .Depth(BREG)) u_breg (
    .clk_i(clock), .rst_ni(reset), .en_i(ceb), .d_i(b), .q_o(b_r)
  );
  dsp48e2_pipe_reg #(.Width(PWidth), .Depth(CREG)) u_creg (
    .clk_i(clock), .rst_ni(reset), .en_i(cec), .d_i(c), .q_o(c_r)
  );

`ifdef DSP48E2_ALU_MULT_EN
  logic signed [44:0] prod;
  assign prod = $signed(a_r[26:0]) * $signed(b_r[17:0]);
  assign m    = {{(PWidth-45){prod[44]}}, prod};
`else
  assign m = '0;
`endif

  // Without an output register the feedback reads 0, which keeps the loop open.
  if (PREG != 0) begin : g_pfb
    assign pfb = p;
  end else begin : g_no_pfb
    assign pfb = '0;
  end

  assign cin = (carryinsel == 3'b000) ? carryin : 1'b0;

  always_comb begin
    x_mux = '0;
    case (x_sel_e'(opmode[1:0]))
      XM:      x_mux = m;
      XP:      x_mux = pfb;
      XAb:     x_mux = {a_r, b_r};
      default: x_mux = '0;
    endcase

    y_mux = '0;
    case (y_sel_e'(opmode[3:2]))
      YOnes:   y_mux = '1;
      YC:      y_mux = c_r;
      default: y_mux = '0;
    endcase

    z_mux = '0;
    case (z_sel_e'(opmode[6:4]))
      ZP, ZPMacc: z_mux = pfb;
      ZC:         z_mux = c_r;
      default:    z_mux = '0;
    endcase

    w_mux = '0;
    case (w_sel_e'(opmode[8:7]))
      WP:      w_mux = pfb;
      WC:      w_mux = c_r;
      default: w_mux = '0;
    endcase

    // Two guard bits: four 48-bit terms plus carry never exceed 50 bits.
    addend = {2'b00, w_mux} + {2'b00, x_mux} + {2'b00, y_mux} + {{(PWidth+1){1'b0}}, cin};

    // Subtract modes are built from inversions of Z or of the sum; their
    // carry is the inverted bit 48 (i.e. a "no borrow" flag).
    sum     = '0;
    alu_res = '0;
    alu_co  = 1'b0;
    case (alu_op_e'(alumode))
      AluZSub: begin
        sum     = {2'b00, ~z_mux} + addend;
        alu_res = ~sum[PWidth-1:0];
        alu_co  = ~sum[PWidth];
      end
      AluNegZAdd: begin
        sum     = {2'b00, ~z_mux} + addend;
        alu_res = sum[PWidth-1:0];
        alu_co  = ~sum[PWidth];
      end
      AluNotSum: begin
        sum     = {2'b00, z_mux} + addend;
        alu_res = ~sum[PWidth-1:0];
        alu_co  = ~sum[PWidth];
      end
      default: begin
        sum     = {2'b00, z_mux} + addend;
        alu_res = sum[PWidth-1:0];
        alu_co  = sum[PWidth];
      end
    endcase
  end

  // Carry travels with P so it is registered and cleared alongside it.
  dsp48e2_pipe_reg #(.Width(PWidth + 1), .Depth(PREG)) u_preg (
    .clk_i(clock), .rst_ni(reset), .en_i(cep), .d_i({alu_co, alu_res}), .q_o(p_out)
  );

  assign p        = p_out[PWidth-1:0];
  assign carryout = p_out[PWidth];
  assign pcout    = p;

endmodule

// File: tb/tb_dsp48e2_alu.sv
// Self-checking bench for dsp48e2_alu: one combinational instance, one with only
// the P register, and one with every register enabled, all sharing stimulus.
module tb_dsp48e2_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic        carryin;
  logic [2:0]  carryinsel;
  logic [8:0]  opmode;
  logic [3:0]  alumode;
  logic        cea, ceb, cec, cep;

  logic [47:0] p_c, pc_c, p_p, pc_p, p_a, pc_a;
  logic        co_c, co_p, co_a;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clock = ~clock;

  dsp48e2_alu #(.AREG(0), .BREG(0), .CREG(0), .PREG(0)) dut_comb (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin),
    .carryinsel(carryinsel), .opmode(opmode), .alumode(alumode),
    .cea(cea), .ceb(ceb), .cec(cec), .cep(cep),
    .p(p_c), .pcout(pc_c), .carryout(co_c)
  );

  dsp48e2_alu #(.AREG(0), .BREG(0), .CREG(0), .PREG(1)) dut_preg (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin),
    .carryinsel(carryinsel), .opmode(opmode), .alumode(alumode),
    .cea(cea), .ceb(ceb), .cec(cec), .cep(cep),
    .p(p_p), .pcout(pc_p), .carryout(co_p)
  );

  dsp48e2_alu #(.AREG(1), .BREG(1), .CREG(1), .PREG(1)) dut_all (
    .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .carryin(carryin),
    .carryinsel(carryinsel), .opmode(opmode), .alumode(alumode),
    .cea(cea), .ceb(ceb), .cec(cec), .cep(cep),
    .p(p_a), .pcout(pc_a), .carryout(co_a)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: arithmetic written directly from the operation formulas, 64-bit wide.
  function automatic logic [48:0] ref_alu(input logic [29:0] ia, input logic [17:0] ib,
                                         input logic [47:0] ic, input logic [47:0] pfb,
                                         input logic icin, input logic [2:0] icsel,
                                         input logic [8:0] opm, input logic [3:0] alum);
    logic [63:0] mask, mv, x, y, z, w, t, s, r;
    logic signed [26:0] sa;
    logic signed [17:0] sb;
    longint prod;
    logic co;
    mask = 64'h0000_FFFF_FFFF_FFFF;
    mv = 64'd0;
    sa = ia[26:0];
    sb = ib;
    prod = longint'(sa) * longint'(sb);
`ifdef DSP48E2_ALU_MULT_EN
    mv = 64'(prod) & mask;
`endif
    case (opm[1:0])
      2'd1: x = mv;
      2'd2: x = {16'd0, pfb};
      2'd3: x = {16'd0, ia, ib};
      default: x = 64'd0;
    endcase
    case (opm[3:2])
      2'd2: y = mask;
      2'd3: y = {16'd0, ic};
      default: y = 64'd0;
    endcase
    case (opm[6:4])
      3'd2, 3'd4: z = {16'd0, pfb};
      3'd3: z = {16'd0, ic};
      default: z = 64'd0;
    endcase
    case (opm[8:7])
      2'd1: w = {16'd0, pfb};
      2'd3: w = {16'd0, ic};
      default: w = 64'd0;
    endcase
    t = w + x + y + ((icsel == 3'd0) ? {63'd0, icin} : 64'd0);
    case (alum)
      4'b0011: begin r = z - t;         s = (mask - z) + t; co = ~s[48]; end
      4'b0001: begin r = t - z - 1;     s = (mask - z) + t; co = ~s[48]; end
      4'b0010: begin r = 64'd0 - z - t - 1; s = z + t;      co = ~s[48]; end
      default: begin r = z + t;         s = z + t;          co = s[48];  end
    endcase
    return {co, r[47:0]};
  endfunction

  // Behavioural pipeline state for the two registered instances.
  logic [48:0] mdl_p, mdl_all;
  logic [29:0] mdl_ra;
  logic [17:0] mdl_rb;
  logic [47:0] mdl_rc;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mdl_p   <= '0;
      mdl_all <= '0;
      mdl_ra  <= '0;
      mdl_rb  <= '0;
      mdl_rc  <= '0;
    end else begin
      if (cep) begin
        mdl_p   <= ref_alu(a, b, c, mdl_p[47:0], carryin, carryinsel, opmode, alumode);
        mdl_all <= ref_alu(mdl_ra, mdl_rb, mdl_rc, mdl_all[47:0], carryin, carryinsel,
                           opmode, alumode);
      end
      if (cea) mdl_ra <= a;
      if (ceb) mdl_rb <= b;
      if (cec) mdl_rc <= c;
    end
  end

  task automatic check_all(input string tag);
    logic [48:0] e;
    e = ref_alu(a, b, c, 48'd0, carryin, carryinsel, opmode, alumode);
    check_eq({tag, "_comb_p"}, 64'(p_c), 64'(e[47:0]));
    check_eq({tag, "_comb_co"}, 64'(co_c), 64'(e[48]));
    check_eq({tag, "_comb_pcout"}, 64'(pc_c), 64'(e[47:0]));
    check_eq({tag, "_preg_p"}, 64'(p_p), 64'(mdl_p[47:0]));
    check_eq({tag, "_preg_co"}, 64'(co_p), 64'(mdl_p[48]));
    check_eq({tag, "_all_p"}, 64'(p_a), 64'(mdl_all[47:0]));
    check_eq({tag, "_all_co"}, 64'(co_a), 64'(mdl_all[48]));
    check_eq({tag, "_all_pcout"}, 64'(pc_a), 64'(mdl_all[47:0]));
  endtask

  initial begin
    logic [47:0] exp39;
    reset = 1'b0;
    a = '0; b = '0; c = '0; carryin = 1'b0; carryinsel = 3'd0;
    opmode = 9'h000; alumode = 4'b0000;
    cea = 1'b1; ceb = 1'b1; cec = 1'b1; cep = 1'b1;

    #3;
    check_eq("rst_preg_p", 64'(p_p), 64'd0);
    check_eq("rst_preg_co", 64'(co_p), 64'd0);
    check_eq("rst_all_pcout", 64'(pc_a), 64'd0);
    check_eq("rst_all_p", 64'(p_a), 64'd0);

    @(negedge clock);
    reset = 1'b1;

    // Same-cycle add.
    opmode = 9'h033; a = 30'd0; b = 18'd5; c = 48'd7;
    #1;
    check_eq("add_p", 64'(p_c), 64'd12);
    check_all("add");

    // 48-bit wrap.
    @(negedge clock);
    c = 48'hFFFF_FFFF_FFFF; a = 30'd0; b = 18'd1;
    #1;
    check_eq("wrap_p", 64'(p_c), 64'd0);
    check_eq("wrap_co", 64'(co_c), 64'd1);

    // 8-bit use.
    @(negedge clock);
    c = 48'hFF; a = 30'd0; b = 18'd1;
    #1;
    check_eq("byte_p", 64'(p_c), 64'h100);
    check_eq("byte_low", 64'(p_c[7:0]), 64'd0);

    // Z minus sum.
    @(negedge clock);
    alumode = 4'b0011; c = 48'd10; a = 30'd0; b = 18'd3;
    #1;
    check_eq("sub_p", 64'(p_c), 64'd7);
    check_all("sub");

    // Output register: one edge of latency, then hold with cep low.
    @(negedge clock);
    alumode = 4'b0000; a = 30'd0; b = 18'd5; c = 48'd7;
    #1;
    check_eq("preg_before_edge", 64'(p_p), 64'd7);
    @(posedge clock);
    #1;
    check_eq("preg_after_edge", 64'(p_p), 64'd12);
    @(negedge clock);
    cep = 1'b0; c = 48'd20;
    @(posedge clock);
    #1;
    check_eq("preg_hold", 64'(p_p), 64'd12);

    // Asynchronous reset between edges.
    reset = 1'b0;
    #1;
    check_eq("async_rst_p", 64'(p_p), 64'd0);
    check_eq("async_rst_pcout", 64'(pc_p), 64'd0);
    check_eq("async_rst_co", 64'(co_p), 64'd0);
    #1;
    reset = 1'b1;

    // Multiplier path.
    @(negedge clock);
    cep = 1'b1; opmode = 9'h005; a = 30'h3FFF_FFFD; b = 18'd4; c = 48'd0;
    carryinsel = 3'd0; carryin = 1'b0;
`ifdef DSP48E2_ALU_MULT_EN
    exp39 = 48'hFFFF_FFFF_FFF4;
`else
    exp39 = 48'd0;
`endif
    #1;
    check_eq("mult_p", 64'(p_c), 64'(exp39));
    check_all("mult");

    // Randomised traffic, including P feedback and clock-enable gaps.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      a = 30'($urandom());
      b = 18'($urandom());
      c = ($urandom_range(0, 7) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom()), $urandom()};
      carryin = 1'($urandom());
      carryinsel = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom());
      opmode = 9'($urandom());
      alumode = ($urandom_range(0, 4) == 0) ? 4'($urandom()) : {2'b00, 2'($urandom())};
      cea = ($urandom_range(0, 3) != 0);
      ceb = ($urandom_range(0, 3) != 0);
      cec = ($urandom_range(0, 3) != 0);
      cep = ($urandom_range(0, 3) != 0);
      #1;
      check_all("rand");
      if (i % 97 == 50) begin
        reset = 1'b0;
        #1;
        check_all("rand_rst");
        #1;
        reset = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dsp48e2_alu.md
DSP48E2_ALU -- requirements
Module: dsp48e2_alu

Interface
REQ-001 The block SHALL expose parameter AREG, default 0, meaning pipeline stages on A (0 or 1).
REQ-002 The block SHALL expose parameter BREG, default 0, meaning pipeline stages on B (0 or 1).
REQ-003 The block SHALL expose parameter CREG, default 0, meaning pipeline stages on C (0 or 1).
REQ-004 The block SHALL expose parameter PREG, default 0, meaning output register stages on P (0 or 1).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase names them (clock, reset).
REQ-006 The ports SHALL be, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- a  in  30  A data, upper part of the A:B concatenation.
- b  in  18  B data, lower part of the A:B concatenation.
- c  in  48  C data.
- carryin  in  1  carry input.
- carryinsel  in  3  carry select.
- opmode  in  9  mux select.
- alumode  in  4  ALU operation.
- cea / ceb / cec / cep  in  1 each  clock enables for the A, B, C and P registers.
- p  out  48  result.
- pcout  out  48  cascade copy of p.
- carryout  out  1  carry out of bit 47.

Function
REQ-007 Mux selects SHALL decode as X = opmode[1:0], Y = opmode[3:2], Z = opmode[6:4], W = opmode[8:7].
REQ-008 X SHALL select as follows:
- 00: 0
- 01: M
- 10: P
- 11: {a,b} (48 bits)
REQ-009 Y SHALL select as follows:
- 00: 0
- 01: 0 (the partial-product pair is collapsed into X)
- 10: all-ones
- 11: C
REQ-010 Z SHALL select as follows:
- 000: 0
- 001: 0 (no PCIN)
- 010: P
- 011: C
- 100: P
- 101, 110, 111: 0
REQ-011 W SHALL select as follows:
- 00: 0
- 01: P
- 10: 0 (RND = 0)
- 11: C
REQ-012 CIN SHALL equal carryin when carryinsel = 000, and 0 otherwise.
REQ-013 ALUMODE 0000 SHALL give p = Z + W + X + Y + CIN.
REQ-014 ALUMODE 0011 SHALL give p = Z − (W + X + Y + CIN).
REQ-015 ALUMODE 0001 SHALL give p = −Z + (W + X + Y + CIN) − 1.
REQ-016 ALUMODE 0010 SHALL give p = −Z − W − X − Y − CIN − 1.
REQ-017 All other ALUMODE codes SHALL behave as 0000.
REQ-018 All arithmetic SHALL be 48-bit modulo 2^48 (ONE48 mode only).
REQ-019 carryout SHALL be bit 48 of the unsigned sum; for subtract modes it SHALL be that bit inverted.
REQ-020 With every register parameter 0, p SHALL be purely combinational (zero latency).
REQ-021 Each register parameter set to 1 SHALL add exactly one cycle on its path.
REQ-022 A register whose CE is 0 SHALL hold its value.
REQ-023 When X, W or Z selects P, the value used SHALL be the current p output: the registered value when PREG = 1, and 0 when PREG = 0, so no combinational loop forms.
REQ-024 pcout SHALL always equal p.

Reset
REQ-025 reset low SHALL immediately clear the A, B, C and P registers to 0, independent of clock.
REQ-026 While reset is low with PREG = 1, p, pcout and carryout SHALL read 0.
REQ-027 Reset deassertion SHALL be synchronised by the integrator; the block itself SHALL need no reset-release handling.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight pipeline data.

Configuration
REQ-029 With macro DSP48E2_ALU_MULT_EN defined, M SHALL be signed a[26:0] × signed b[17:0], sign-extended to 48 bits.
REQ-030 With DSP48E2_ALU_MULT_EN undefined, M SHALL be 0 and no multiplier logic SHALL be synthesised.

Structure
REQ-031 Package dsp48e2_alu_pkg SHALL hold the width constants (30/18/48), the X/Y/Z/W select encodings and the ALUMODE encodings.
REQ-032 One sub-module, dsp48e2_pipe_reg, SHALL implement the optional register: parameterised width and depth 0/1, with CE and asynchronous reset. It is instanced for A, B, C and P.

Verification
REQ-033 All registers 0, opmode 0x033, alumode 0000, a = 0, b = 5, c = 7 -> p = 12 in the same cycle.
REQ-034 Wrap: c = 0xFFFF_FFFF_FFFF, {a,b} = 1, opmode 0x033 -> p = 0 and carryout = 1.
REQ-035 8-bit use: c = 0xFF, b = 0x01 -> p = 0x100, so p[7:0] = 0x00.
REQ-036 alumode 0011, opmode 0x033, c = 10, {a,b} = 3 -> p = 7.
REQ-037 PREG = 1, cep = 1: p updates exactly one edge after the inputs change; with cep = 0, p holds.
REQ-038 Reset pulsed low between clock edges with PREG = 1 and p = 12 -> p = 0 immediately.
REQ-039 DSP48E2_ALU_MULT_EN defined, opmode 0x005, a = −3, b = 4 -> p = 0xFFFF_FFFF_FFF4; with the macro undefined, the same stimulus gives p = 0.
